secded_scrub_ctrl: RTL and testbench

Background memory scrubber controller for 72-bit SECDED-protected storage (64 data + 8 check bits). It walks an address range, reads each word, passes it through the registered SECDED decoder and writes back the corrected word on a single-bit error. It also counts correctable and uncorrectable errors and records the last uncorrectable address. It sits between the memory's shared access port and the decoder and yields to host traffic.

---
 rtl/secded_scrub_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_secded_scrub_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/secded_scrub_ctrl.sv
// secded_scrub_ctrl
// Background scrubber for 72-bit SECDED words (64 data + 8 check). It walks
// addresses 0 .. 2^ADDR_W-1 and reads each word through an external
// registered decoder. A word with a single-bit error is written back
// corrected. Corrected and uncorrectable errors are counted, and the address
// of the most recent uncorrectable word is kept. The scrubber yields the
// shared memory port to host traffic.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start, continuous,    pass control: start pulse, wrap-around enable,
//   stop, gap             stop request, idle cycles between words
//   clear_counts          clears ce_count / ue_count / ue_valid
//   host_busy             host owns the memory port; no new request
//   mem_req/we/addr/wdata memory request side
//   mem_gnt/rvalid/rdata  memory response side
//   dec_data_in           word to decoder (mem_rdata while waiting, else 0)
//   dec_data_out,         decoder result, one cycle after dec_data_in
//   dec_single_error,
//   dec_double_error
//   busy, pass_done       status
//   ce_count, ue_count,   saturating error counters, last uncorrectable
//   ue_addr, ue_valid     address and its valid flag
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start
// GAP     | counting down inter-word gap
// RD_REQ  | read request pending (raised once host_busy is low)
// RD_WAIT | read granted, waiting for rvalid; rdata drives decoder
// DECODE  | sample decoder flags, update counters
// WR_REQ  | write-back of corrected word pending
// NEXT    | advance address, end pass, or stop

module secded_scrub_ctrl #(
  parameter int ADDR_W = 10,
  parameter int GAP_W  = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              continuous,
  input  logic              stop,
  input  logic [GAP_W-1:0]  gap,
  input  logic              clear_counts,
  input  logic              host_busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [71:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [71:0]       mem_rdata,
  output logic [71:0]       dec_data_in,
  input  logic [71:0]       dec_data_out,
  input  logic              dec_single_error,
  input  logic              dec_double_error,
  output logic              busy,
  output logic              pass_done,
  output logic [CNT_W-1:0]  ce_count,
  output logic [CNT_W-1:0]  ue_count,
  output logic [ADDR_W-1:0] ue_addr,
  output logic              ue_valid
);

  typedef enum logic [2:0] {
    IDLE, GAP, RD_REQ, RD_WAIT, DECODE, WR_REQ, NEXT
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  state_t             state, state_d;
  logic [ADDR_W-1:0]  addr, addr_d;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [71:0]        wdata_q, wdata_d;
  logic [CNT_W-1:0]   ce_q, ce_d;
  logic [CNT_W-1:0]   ue_q, ue_d;
  logic [ADDR_W-1:0]  ue_addr_q, ue_addr_d;
  logic               ue_valid_q, ue_valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr       <= '0;
      gap_cnt    <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      ce_q       <= '0;
      ue_q       <= '0;
      ue_addr_q  <= '0;
      ue_valid_q <= 1'b0;
    end else begin
      state      <= state_d;
      addr       <= addr_d;
      gap_cnt    <= gap_cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      ce_q       <= ce_d;
      ue_q       <= ue_d;
      ue_addr_q  <= ue_addr_d;
      ue_valid_q <= ue_valid_d;
    end
  end

  always_comb begin
    state_d    = state;
    addr_d     = addr;
    gap_cnt_d  = gap_cnt;
    req_d      = req_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    ce_d       = ce_q;
    ue_d       = ue_q;
    ue_addr_d  = ue_addr_q;
    ue_valid_d = ue_valid_q;

    case (state)
      IDLE: begin
        if (start) begin
          addr_d    = '0;
          gap_cnt_d = gap;
          state_d   = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_d = RD_REQ;
        else               gap_cnt_d = gap_cnt - GAP_W'(1);
      end
      RD_REQ, WR_REQ: begin
        // host_busy only gates raising a request; once raised it is held
        // with a stable address until granted.
        if (req_q) begin
          if (mem_gnt) begin
            req_d   = 1'b0;
            we_d    = 1'b0;
            state_d = (state == RD_REQ) ? RD_WAIT : NEXT;
          end
        end else if (!host_busy) begin
          req_d = 1'b1;
          we_d  = (state == WR_REQ);
        end
      end
      RD_WAIT: begin
        if (mem_rvalid) state_d = DECODE;
      end
      DECODE: begin
        if (dec_single_error) begin
          if (ce_q != CNT_MAX) ce_d = ce_q + CNT_W'(1);
          wdata_d = dec_data_out;
          state_d = WR_REQ;
        end else if (dec_double_error) begin
          if (ue_q != CNT_MAX) ue_d = ue_q + CNT_W'(1);
          ue_addr_d  = addr;
          ue_valid_d = 1'b1;
          state_d    = NEXT;
        end else begin
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (stop) begin
          state_d = IDLE;
        end else if (addr == ADDR_MAX) begin
          if (continuous) begin
            addr_d    = '0;
            gap_cnt_d = gap;
            state_d   = GAP;
          end else begin
            state_d = IDLE;
          end
        end else begin
          addr_d    = addr + ADDR_W'(1);
          gap_cnt_d = gap;
          state_d   = GAP;
        end
      end
      default: state_d = IDLE;
    endcase

    // Clear takes priority over any increment or set in the same cycle.
    if (clear_counts) begin
      ce_d       = '0;
      ue_d       = '0;
      ue_valid_d = 1'b0;
    end
  end

  assign mem_req     = req_q;
  assign mem_we      = we_q;
  assign mem_addr    = addr;
  assign mem_wdata   = wdata_q;
  assign dec_data_in = (state == RD_WAIT) ? mem_rdata : 72'd0;
  assign busy        = (state != IDLE);
  assign pass_done   = (state == NEXT) && (addr == ADDR_MAX);
  assign ce_count    = ce_q;
  assign ue_count    = ue_q;
  assign ue_addr     = ue_addr_q;
  assign ue_valid    = ue_valid_q;

endmodule

// File: tb/tb_secded_scrub_ctrl.sv
module tb_secded_scrub_ctrl;

  localparam int AW = 3;
  localparam int GW = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, continuous = 1'b0, stop = 1'b0;
  logic [GW-1:0] gap = '0;
  logic          clear_counts = 1'b0, host_busy = 1'b0;
  logic          mem_req, mem_we, mem_gnt;
  logic [AW-1:0] mem_addr;
  logic [71:0]   mem_wdata, dec_data_in;
  logic          mem_rvalid = 1'b0;
  logic [71:0]   mem_rdata = '0;
  logic [71:0]   dec_data_out = '0;
  logic          dec_single_error = 1'b0, dec_double_error = 1'b0;
  logic          busy, pass_done, ue_valid;
  logic [CW-1:0] ce_count, ue_count;
  logic [AW-1:0] ue_addr;

  logic          gnt_en = 1'b1, block_wr = 1'b0;
  logic [71:0]   good [8];
  logic [71:0]   flip [8];
  logic [AW-1:0] rd_addr_q = '0;

  int            rd_cnt = 0, wr_cnt = 0, pd_cnt = 0;
  logic [AW-1:0] last_wr_addr = '0, last_rd_addr = '0;
  logic [71:0]   last_wr_data = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  secded_scrub_ctrl #(.ADDR_W(AW), .GAP_W(GW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
    .stop(stop), .gap(gap), .clear_counts(clear_counts),
    .host_busy(host_busy), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .dec_data_in(dec_data_in), .dec_data_out(dec_data_out),
    .dec_single_error(dec_single_error), .dec_double_error(dec_double_error),
    .busy(busy), .pass_done(pass_done), .ce_count(ce_count),
    .ue_count(ue_count), .ue_addr(ue_addr), .ue_valid(ue_valid)
  );

  assign mem_gnt = mem_req & gnt_en & ~(block_wr & mem_we);

  // Memory model: read data returned one cycle after the grant.
  always @(posedge clk) begin
    mem_rvalid <= 1'b0;
    if (pass_done) pd_cnt = pd_cnt + 1;
    if (mem_req && mem_gnt) begin
      if (mem_we) begin
        wr_cnt       = wr_cnt + 1;
        last_wr_addr = mem_addr;
        last_wr_data = mem_wdata;
      end else begin
        rd_cnt       = rd_cnt + 1;
        last_rd_addr = mem_addr;
        mem_rvalid  <= 1'b1;
        mem_rdata   <= good[mem_addr] ^ flip[mem_addr];
        rd_addr_q   <= mem_addr;
      end
    end
  end

  // Decoder stub: compares the word against the known-good value of the
  // address last read; one differing bit is correctable, two are not.
  always @(posedge clk) begin
    int pc;
    pc = $countones(dec_data_in ^ good[rd_addr_q]);
    dec_single_error <= (pc == 1);
    dec_double_error <= (pc == 2);
    dec_data_out     <= (pc == 1) ? good[rd_addr_q] : dec_data_in;
  end

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [71:0] sflip(input int a);
    logic [71:0] t;
    t = '0;
    t[(a * 7 + 3) % 72] = 1'b1;
    return t;
  endfunction

  function automatic logic [71:0] dflip(input int a);
    logic [71:0] t;
    t = '0;
    t[(a * 5) % 72]      = 1'b1;
    t[(a * 5 + 37) % 72] = 1'b1;
    return t;
  endfunction

  task automatic set_flips(input logic [7:0] smask, input logic [7:0] dmask);
    for (int i = 0; i < 8; i++)
      flip[i] = smask[i] ? sflip(i) : (dmask[i] ? dflip(i) : 72'd0);
  endtask

  task automatic clr();
    @(negedge clk) clear_counts = 1'b1;
    @(negedge clk) clear_counts = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("busy_after_start", 72'(busy), 72'd1);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 72'(busy), 72'd0);
  endtask

  typedef struct {
    string      name;
    int         gap;
    logic [7:0] smask;
    logic [7:0] dmask;
    int         rd, wr, ce, ue;
    logic       uv;
    int         ua, pd, wa;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int rd0, wr0, pd0, n;
    logic seen, stable;
    logic [AW-1:0] a0;

    for (int i = 0; i < 8; i++) begin
      good[i] = {8'hA5 ^ 8'(i), 64'h0123_4567_89AB_CDEF ^ {8{8'(i * 17 + 1)}}};
      flip[i] = '0;
    end

    vecs[0] = '{"clean_gap0",  0, 8'h00, 8'h00, 8, 0, 0, 0, 1'b0, 0, 1, -1};
    vecs[1] = '{"single_a5",   0, 8'h20, 8'h00, 8, 1, 1, 0, 1'b0, 0, 1,  5};
    vecs[2] = '{"double_a2",   0, 8'h00, 8'h04, 8, 0, 0, 1, 1'b1, 2, 1, -1};
    vecs[3] = '{"clean_gap3",  3, 8'h00, 8'h00, 8, 0, 0, 0, 1'b0, 0, 1, -1};
    vecs[4] = '{"ce_saturate", 0, 8'hFF, 8'h00, 8, 8, 3, 0, 1'b0, 0, 1,  7};
    vecs[5] = '{"ue_saturate", 2, 8'h00, 8'h0F, 8, 0, 0, 3, 1'b1, 3, 1, -1};
    vecs[6] = '{"mixed",       1, 8'h81, 8'h10, 8, 2, 2, 1, 1'b1, 4, 1,  7};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_mem_req",   72'(mem_req),   72'd0);
    chk("rst_mem_we",    72'(mem_we),    72'd0);
    chk("rst_mem_addr",  72'(mem_addr),  72'd0);
    chk("rst_mem_wdata", mem_wdata,      72'd0);
    chk("rst_dec_in",    dec_data_in,    72'd0);
    chk("rst_busy",      72'(busy),      72'd0);
    chk("rst_pass_done", 72'(pass_done), 72'd0);
    chk("rst_ce",        72'(ce_count),  72'd0);
    chk("rst_ue",        72'(ue_count),  72'd0);
    chk("rst_ue_addr",   72'(ue_addr),   72'd0);
    chk("rst_ue_valid",  72'(ue_valid),  72'd0);
    rst_n = 1'b1;

    // Single passes from the table
    for (int v = 0; v < 7; v++) begin
      clr();
      set_flips(vecs[v].smask, vecs[v].dmask);
      gap = GW'(vecs[v].gap);
      rd0 = rd_cnt; wr0 = wr_cnt; pd0 = pd_cnt;
      pulse_start();
      wait_idle({vecs[v].name, "_timeout"});
      chk({vecs[v].name, "_reads"},  72'(rd_cnt - rd0), 72'(vecs[v].rd));
      chk({vecs[v].name, "_writes"}, 72'(wr_cnt - wr0), 72'(vecs[v].wr));
      chk({vecs[v].name, "_pdone"},  72'(pd_cnt - pd0), 72'(vecs[v].pd));
      chk({vecs[v].name, "_ce"},     72'(ce_count),     72'(vecs[v].ce));
      chk({vecs[v].name, "_ue"},     72'(ue_count),     72'(vecs[v].ue));
      chk({vecs[v].name, "_uvalid"}, 72'(ue_valid),     72'(vecs[v].uv));
      if (vecs[v].uv)
        chk({vecs[v].name, "_uaddr"}, 72'(ue_addr), 72'(vecs[v].ua));
      if (vecs[v].wa >= 0) begin
        chk({vecs[v].name, "_waddr"}, 72'(last_wr_addr), 72'(vecs[v].wa));
        chk({vecs[v].name, "_wdata"}, last_wr_data, good[vecs[v].wa]);
      end
      chk({vecs[v].name, "_dec_in_idle"}, dec_data_in, 72'd0);
    end

    // clear_counts after errors
    clr();
    chk("clear_ce", 72'(ce_count), 72'd0);
    chk("clear_ue", 72'(ue_count), 72'd0);
    chk("clear_uv", 72'(ue_valid), 72'd0);

    // host_busy gating and request stability
    set_flips(8'h00, 8'h00);
    gap = '0;
    host_busy = 1'b1;
    rd0 = rd_cnt;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen = seen | mem_req;
    end
    chk("hb_no_req", 72'(seen), 72'd0);
    gnt_en = 1'b0;
    host_busy = 1'b0;
    n = 0;
    while (!mem_req && n < 10) begin @(negedge clk); n++; end
    chk("hb_req_raised", 72'(mem_req), 72'd1);
    a0 = mem_addr;
    chk("hb_req_addr", 72'(a0), 72'd0);
    stable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      host_busy = ~host_busy;
      @(negedge clk);
      stable = stable & mem_req & ~mem_we & (mem_addr == a0);
    end
    chk("hb_req_stable", 72'(stable), 72'd1);
    host_busy = 1'b0;
    gnt_en = 1'b1;
    wait_idle("hb_timeout");
    chk("hb_reads", 72'(rd_cnt - rd0), 72'd8);

    // clear_counts coinciding with a ce increment
    clr();
    set_flips(8'h01, 8'h00);
    wr0 = wr_cnt;
    pulse_start();
    n = 0;
    while (!mem_rvalid && n < 50) begin @(negedge clk); n++; end
    chk("cc_rvalid_seen", 72'(mem_rvalid), 72'd1);
    @(negedge clk) clear_counts = 1'b1;
    @(negedge clk) clear_counts = 1'b0;
    wait_idle("cc_timeout");
    chk("cc_ce_zero", 72'(ce_count), 72'd0);
    chk("cc_write_done", 72'(wr_cnt - wr0), 72'd1);

    // clear_counts coinciding with a ue increment / ue_valid set
    set_flips(8'h00, 8'h01);
    pulse_start();
    n = 0;
    while (!mem_rvalid && n < 50) begin @(negedge clk); n++; end
    @(negedge clk) clear_counts = 1'b1;
    @(negedge clk) clear_counts = 1'b0;
    wait_idle("cu_timeout");
    chk("cu_ue_zero", 72'(ue_count), 72'd0);
    chk("cu_uv_zero", 72'(ue_valid), 72'd0);

    // stop during the read of address 4
    set_flips(8'h00, 8'h00);
    rd0 = rd_cnt; pd0 = pd_cnt;
    pulse_start();
    n = 0;
    while (!(mem_req && !mem_we && mem_addr == 3'd4) && n < 200) begin
      @(negedge clk); n++;
    end
    stop = 1'b1;
    wait_idle("stop_timeout");
    stop = 1'b0;
    chk("stop_reads",   72'(rd_cnt - rd0), 72'd5);
    chk("stop_last_rd", 72'(last_rd_addr), 72'd4);
    chk("stop_pdone",   72'(pd_cnt - pd0), 72'd0);

    // continuous: three passes, disabled after the second pass_done
    rd0 = rd_cnt; pd0 = pd_cnt;
    continuous = 1'b1;
    pulse_start();
    n = 0;
    while ((pd_cnt - pd0) < 2 && n < 500) begin @(negedge clk); n++; end
    continuous = 1'b0;
    wait_idle("cont_timeout");
    chk("cont_pdone", 72'(pd_cnt - pd0), 72'd3);
    chk("cont_reads", 72'(rd_cnt - rd0), 72'd24);

    // reset while a write-back is pending
    clr();
    set_flips(8'h01, 8'h00);
    block_wr = 1'b1;
    pulse_start();
    n = 0;
    while (!(mem_req && mem_we) && n < 50) begin @(negedge clk); n++; end
    chk("wr_req_pending", 72'(mem_req & mem_we), 72'd1);
    chk("wr_ce_before_rst", 72'(ce_count), 72'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wr_mem_req",   72'(mem_req),   72'd0);
    chk("rst_wr_mem_we",    72'(mem_we),    72'd0);
    chk("rst_wr_mem_addr",  72'(mem_addr),  72'd0);
    chk("rst_wr_mem_wdata", mem_wdata,      72'd0);
    chk("rst_wr_busy",      72'(busy),      72'd0);
    chk("rst_wr_ce",        72'(ce_count),  72'd0);
    chk("rst_wr_dec_in",    dec_data_in,    72'd0);
    chk("rst_wr_pass_done", 72'(pass_done), 72'd0);
    @(negedge clk);
    rst_n = 1'b1;
    block_wr = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
